// File: rtl/scroll_pkg.sv
// Shared character codes and FSM state encoding for the scrolling display engine.
package scroll_pkg;

  localparam int unsigned CODE_W = 5;

  // Character codes; 0-9 are the decimal digits themselves
  localparam logic [CODE_W-1:0] CH_H     = 5'd10;
  localparam logic [CODE_W-1:0] CH_E     = 5'd11;
  localparam logic [CODE_W-1:0] CH_U     = 5'd12;
  localparam logic [CODE_W-1:0] CH_L     = 5'd13;
  localparam logic [CODE_W-1:0] CH_J     = 5'd14;
  localparam logic [CODE_W-1:0] CH_Y     = 5'd15;
  localparam logic [CODE_W-1:0] CH_SPACE = 5'd16;
  localparam logic [CODE_W-1:0] CH_BLANK = 5'd31;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } scroll_state_e;

endpackage

// File: rtl/scroll_prescaler.sv
// Step prescaler: counts 0..L-1 while enabled, ticks on the last count.
module scroll_prescaler #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;
  logic             terminal;

  // A divider of 0 behaves as 1; >= also covers div shrinking below the count
  assign last     = (div == '0) ? '0 : div - DIV_W'(1);
  assign terminal = (cnt >= last);
  assign tick     = enable && !clear && terminal;

  // Counter: clear wins, otherwise advance only while enabled (frozen, not cleared)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/scroll_engine.sv
// Scrolling message engine: circular buffer, stepped position, windowed digit output.
module scroll_engine
  import scroll_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CHAR_W  = 5,
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned BLANK   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              step_div,
  input  logic                          pause,
  input  logic                          dir,
  input  logic                          once,
  input  logic [$clog2(MAX_LEN):0]      msg_len,
  input  logic                          restart,
  input  logic                          wr_en,
  input  logic [$clog2(MAX_LEN)-1:0]    wr_addr,
  input  logic [CHAR_W-1:0]             wr_data,
  output logic [DIGITS*CHAR_W-1:0]      chars,
  output logic [$clog2(MAX_LEN)-1:0]    pos,
  output logic                          wrap,
  output logic                          done
);

  localparam int unsigned ADDR_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned SUM_W  = LEN_W + 1;

  scroll_state_e     state, state_next;
  logic [ADDR_W-1:0] pos_next;
  logic              wrap_next;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] len_last;
  logic [ADDR_W-1:0] pos_win;
  logic              pos_oob;
  logic              at_end;
  logic              tick;
  logic              presc_en;
  logic [CHAR_W-1:0] msg_buf [MAX_LEN];

  // Effective length clamped to [DIGITS, MAX_LEN]
  always_comb begin
    len = msg_len;
    if (msg_len < LEN_W'(DIGITS)) begin
      len = LEN_W'(DIGITS);
    end else if (msg_len > LEN_W'(MAX_LEN)) begin
      len = LEN_W'(MAX_LEN);
    end
  end

  assign len_last = ADDR_W'(len - LEN_W'(1));
  assign pos_oob  = (LEN_W'(pos) >= len);
  assign at_end   = dir ? (pos == '0) : (pos == len_last);

  // Prescaler resumes on the same edge that HOLD is left
  assign presc_en = ((state == ST_RUN) || (state == ST_HOLD)) && !pause;

  scroll_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (presc_en),
    .clear  (restart),
    .div    (step_div),
    .tick   (tick)
  );

  // State, position and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pos   <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      pos   <= pos_next;
      wrap  <= wrap_next;
      done  <= (state_next == ST_DONE);
    end
  end

  // Next state and position: restart > out-of-range fixup > step
  always_comb begin
    state_next = state;
    pos_next   = pos;
    wrap_next  = 1'b0;
    if (restart) begin
      state_next = ST_RUN;
      pos_next   = '0;
    end else begin
      unique case (state)
        ST_RUN:  if (pause) state_next = ST_HOLD;
        ST_HOLD: if (!pause) state_next = ST_RUN;
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_RUN;
      endcase
      if (pos_oob) begin
        pos_next = '0;
      end else if (tick) begin
        if (at_end) begin
          if (once) begin
            state_next = ST_DONE;
          end else begin
            pos_next  = dir ? len_last : '0;
            wrap_next = 1'b1;
          end
        end else begin
          pos_next = dir ? pos - ADDR_W'(1) : pos + ADDR_W'(1);
        end
      end
    end
  end

  // Message buffer: blank on reset, writable in every state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        msg_buf[i] <= CHAR_W'(BLANK);
      end
    end else if (wr_en && (LEN_W'(wr_addr) < LEN_W'(MAX_LEN))) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  // Window base; an out-of-range pos is shown as 0 for its single cycle
  assign pos_win = pos_oob ? '0 : pos;

  // Digit k shows buf[(pos + DIGITS-1-k) mod len]; sum < 2*len so one subtract suffices
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [SUM_W-1:0]  sum;
    logic [ADDR_W-1:0] idx;
    assign sum = SUM_W'(pos_win) + SUM_W'(DIGITS - 1 - k);
    assign idx = (sum >= SUM_W'(len)) ? ADDR_W'(sum - SUM_W'(len)) : ADDR_W'(sum);
    assign chars[k*CHAR_W +: CHAR_W] = msg_buf[idx];
  end

endmodule

// File: tb/tb_scroll_engine.sv
// Directed bench for scroll_engine with hand-computed expectations.
module tb_scroll_engine;

  logic        clk;
  logic        rst_n;
  logic [23:0] step_div;
  logic        pause;
  logic        dir;
  logic        once;
  logic [5:0]  msg_len;
  logic        restart;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [39:0] chars;
  logic [4:0]  pos;
  logic        wrap;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  scroll_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_div (step_div),
    .pause    (pause),
    .dir      (dir),
    .once     (once),
    .msg_len  (msg_len),
    .restart  (restart),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .chars    (chars),
    .pos      (pos),
    .wrap     (wrap),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  logic [4:0] msg [16];
  int wraps;

  initial begin
    msg = '{5'd10, 5'd11, 5'd12, 5'd16, 5'd13, 5'd14, 5'd15, 5'd16,
            5'd2,  5'd0,  5'd1,  5'd9,  5'd0,  5'd0,  5'd0,  5'd0};
    rst_n = 1'b0; step_div = 24'd3; pause = 1'b0; dir = 1'b0; once = 1'b0;
    msg_len = 6'd24; restart = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state
    step(2);
    chk("rst_pos",   64'(pos),   64'd0);
    chk("rst_wrap",  64'(wrap),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_chars", 64'(chars), 64'({8{5'd16}}));

    // Loop scroll, step_div=3, len 24
    rst_n = 1'b1;
    step(2);  chk("first_tick_pre", 64'(pos), 64'd0);
    step(1);  chk("first_tick",     64'(pos), 64'd1);
    step(66); chk("pos23",  64'(pos), 64'd23);
              chk("nowrap", 64'(wrap), 64'd0);
    step(3);  chk("wrap_pos0", 64'(pos), 64'd0);
              chk("wrap_hi",   64'(wrap), 64'd1);
    step(1);  chk("wrap_lo",   64'(wrap), 64'd0);
    wraps = 0;
    for (int i = 0; i < 72; i++) begin
      step(1);
      if (wrap) wraps++;
    end
    chk("wrap_per_72", 64'(wraps), 64'd1);

    // Load message at 8..23, then park at pos 8
    pause = 1'b1;
    for (int i = 0; i < 16; i++) wr(5'(8 + i), msg[i]);
    step_div = 24'd1; restart = 1'b1; pause = 1'b0;
    step(1);  chk("restart_pos", 64'(pos), 64'd0);
    restart = 1'b0;
    step(8);  pause = 1'b1;
    chk("pos8", 64'(pos), 64'd8);
    chk("win_pos8", 64'(chars),
        64'({5'd10, 5'd11, 5'd12, 5'd16, 5'd13, 5'd14, 5'd15, 5'd16}));
    step(4);  chk("pause_hold", 64'(pos), 64'd8);

    // Window across the buffer end
    pause = 1'b0;
    step(12); pause = 1'b1;
    chk("pos20", 64'(pos), 64'd20);
    chk("win_pos20", 64'(chars),
        64'({5'd0, 5'd0, 5'd0, 5'd0, 5'd16, 5'd16, 5'd16, 5'd16}));

    // Write and tick on the same edge
    pause = 1'b0; wr_en = 1'b1; wr_addr = 5'd21; wr_data = 5'd9;
    step(1);  pause = 1'b1; wr_en = 1'b0;
    chk("wr_tick_pos", 64'(pos), 64'd21);
    chk("wr_tick_win", 64'(chars),
        64'({5'd9, 5'd0, 5'd0, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16}));

    // Shrink length below pos
    msg_len = 6'd16;
    step(1);  chk("shrink_pos",  64'(pos),  64'd0);
              chk("shrink_wrap", 64'(wrap), 64'd0);

    // msg_len=3 clamps to 8
    msg_len = 6'd3; pause = 1'b0;
    step(7);  chk("clamp8_pos7", 64'(pos), 64'd7);
    step(1);  chk("clamp8_wrap_pos", 64'(pos), 64'd0);
              chk("clamp8_wrap",     64'(wrap), 64'd1);

    // msg_len=40 clamps to 32, dir=1 wraps to len-1
    msg_len = 6'd40; dir = 1'b1;
    step(1);  pause = 1'b1;
    chk("dir1_wrap_pos", 64'(pos), 64'd31);
    chk("dir1_wrap",     64'(wrap), 64'd1);

    // One-shot: len 10, step_div 1
    restart = 1'b1; pause = 1'b0; once = 1'b1; msg_len = 6'd10; dir = 1'b0;
    step(1);  restart = 1'b0;
    chk("once_start", 64'(pos), 64'd0);
    step(9);  chk("once_pos9",    64'(pos),  64'd9);
              chk("once_notdone", 64'(done), 64'd0);
    step(1);  chk("once_done",    64'(done), 64'd1);
              chk("once_hold9",   64'(pos),  64'd9);
              chk("once_nowrap",  64'(wrap), 64'd0);
    step(3);  chk("once_stay9",   64'(pos),  64'd9);
              chk("once_stay_done", 64'(done), 64'd1);
    restart = 1'b1;
    step(1);  restart = 1'b0;
    chk("once_restart_pos",  64'(pos),  64'd0);
    chk("once_restart_done", 64'(done), 64'd0);

    // Pause at prescaler count 1 with step_div=4
    step_div = 24'd4; once = 1'b0; msg_len = 6'd24; restart = 1'b1;
    step(1);  restart = 1'b0;
    step(1);  pause = 1'b1;
    step(10); chk("pause_pos", 64'(pos), 64'd0);
    pause = 1'b0;
    step(2);  chk("release_pre", 64'(pos), 64'd0);
    step(1);  chk("release_tick", 64'(pos), 64'd1);
    step(3);  chk("period4_pre", 64'(pos), 64'd1);
    step(1);  chk("period4", 64'(pos), 64'd2);

    // Restart on the tick edge
    step(3);  restart = 1'b1;
    step(1);  restart = 1'b0;
    chk("restart_tick_pos", 64'(pos), 64'd0);
    step(3);  chk("restart_cnt_pre", 64'(pos), 64'd0);
    step(1);  chk("restart_cnt", 64'(pos), 64'd1);

    // Reset mid-run
    step(2);  rst_n = 1'b0;
    step(1);  chk("midrst_pos",   64'(pos),   64'd0);
              chk("midrst_chars", 64'(chars), 64'({8{5'd16}}));
              chk("midrst_done",  64'(done),  64'd0);
    rst_n = 1'b1;
    step(3);  chk("postrst_pre", 64'(pos), 64'd0);
    step(1);  chk("postrst_tick", 64'(pos), 64'd1);

    // Right scroll wraps from 0 to len-1
    dir = 1'b1; step_div = 24'd1;
    step(1);  chk("dir1_pos0", 64'(pos), 64'd0);
    step(1);  chk("dir1_pos23", 64'(pos), 64'd23);
              chk("dir1_wrap24", 64'(wrap), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
